// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction word layout,
// core opcodes, the idle instruction and the sequencer state type.
package inst_sequencer_pkg;

  localparam int INST_W_DEF = 16;

  // Field positions inside {opcode, r1, r2/data, r3/data}
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int R1_MSB  = 11;
  localparam int R1_LSB  = 8;
  localparam int R2_MSB  = 7;
  localparam int R2_LSB  = 4;
  localparam int R3_MSB  = 3;
  localparam int R3_LSB  = 0;

  localparam logic [3:0] OP_MVR = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_STB = 4'h2;
  localparam logic [3:0] OP_RDS = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;

  // RDS writes no register, so the core can execute it harmlessly forever.
  localparam logic [INST_W_DEF-1:0] DEFAULT_IDLE_WORD = {OP_RDS, 12'h000};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/inst_sequencer_mem.sv
// Program store: DEPTH x INST_W register array, synchronous write,
// asynchronous read.
module inst_mem #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem_q [DEPTH];

  // NOTE: storage arrays get no reset; the sequencer's count gates every read,
  // and leaving the reset out keeps this a plain register file.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// Loads a short program over a valid/ready port and replays it to the CPU
// core one word per clock, driving an idle instruction whenever not running.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                INST_W    = INST_W_DEF,
  parameter logic [INST_W-1:0] IDLE_WORD = DEFAULT_IDLE_WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [INST_W-1:0]          load_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       loop_en,
  input  logic                       halt_req,
  output logic [INST_W-1:0]          inst_out,
  output logic                       inst_valid,
  output logic [$clog2(DEPTH)-1:0]   pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic              inst_valid_q, inst_valid_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [AW-1:0]     rd_addr;
  logic [INST_W-1:0] rd_data;
  logic              hs;
  logic              last;

  inst_mem #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign hs   = load_valid && load_ready;
  assign last = (pc_q == AW'(count_q - 1'b1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      pc_q         <= '0;
      inst_out_q   <= IDLE_WORD;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      done_q       <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = inst_valid_q;
    done_d       = 1'b0;
    mem_we       = 1'b0;
    rd_addr      = '0;

    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d  = '0;
          wr_ptr_d = '0;
        end else begin
          if (hs) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
          if (start && (count_q != '0 || hs)) begin
            state_d      = RUN;
            pc_d         = '0;
            inst_valid_d = 1'b1;
            // An empty store gets its first word this very cycle: bypass it.
            inst_out_d   = (count_q == '0) ? load_data : rd_data;
          end
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d      = IDLE;
          inst_valid_d = 1'b0;
          inst_out_d   = IDLE_WORD;
        end else if (last && !loop_en) begin
          state_d      = IDLE;
          inst_valid_d = 1'b0;
          inst_out_d   = IDLE_WORD;
          done_d       = 1'b1;
        end else begin
          rd_addr    = last ? '0 : pc_q + 1'b1;
          pc_d       = rd_addr;
          inst_out_d = rd_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));
    busy       = (state_q == RUN);
    inst_out   = inst_out_q;
    inst_valid = inst_valid_q;
    pc         = pc_q;
    count      = count_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: load/issue, full store, looping with
// halt, empty-start corner cases and reset during a run.
module tb_inst_sequencer;

  localparam int DEPTH  = 16;
  localparam int INST_W = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [INST_W-1:0] load_data = '0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              loop_en = 1'b0;
  logic              halt_req = 1'b0;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic [AW-1:0]     pc;
  logic [AW:0]       count;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  logic [INST_W-1:0] prog [DEPTH];

  inst_sequencer #(
    .DEPTH     (DEPTH),
    .INST_W    (INST_W),
    .IDLE_WORD (16'h3000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .clear      (clear),
    .start      (start),
    .loop_en    (loop_en),
    .halt_req   (halt_req),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .pc         (pc),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [INST_W-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [INST_W-1:0] w, input int p);
    check({tag, "_data"},  32'(inst_out),   32'(w));
    check({tag, "_valid"}, 32'(inst_valid), 1);
    check({tag, "_pc"},    32'(pc),         32'(p));
    check({tag, "_done"},  32'(done),       0);
  endtask

  task automatic expect_idle(input string tag, input int exp_done);
    check({tag, "_data"},  32'(inst_out),   'h3000);
    check({tag, "_valid"}, 32'(inst_valid), 0);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_done"},  32'(done),       32'(exp_done));
  endtask

  initial begin
    #12;
    expect_idle("rst", 0);
    check("rst_count", 32'(count),      0);
    check("rst_pc",    32'(pc),         0);
    check("rst_ready", 32'(load_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic three-word program
    load_word(16'h1A55);
    load_word(16'h0A0B);
    load_word(16'h2B00);
    check("t1_count", 32'(count), 3);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_issue("t1_w0", 16'h1A55, 0);
    check("t1_busy", 32'(busy), 1);
    step();
    expect_issue("t1_w1", 16'h0A0B, 1);
    step();
    expect_issue("t1_w2", 16'h2B00, 2);
    step();
    expect_idle("t1_end", 1);
    step();
    expect_idle("t1_after", 0);

    // Full store, overflow attempt, two full passes
    do_clear();
    check("t2_clr_count", 32'(count), 0);
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = 16'h4000 + INST_W'(i) * 16'h0101;
      load_word(prog[i]);
    end
    check("t2_ready_full", 32'(load_ready), 0);
    check("t2_count_full", 32'(count), 16);
    load_word(16'hFFFF);
    check("t2_count_17", 32'(count), 16);
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        expect_issue($sformatf("t2_p%0d_w%0d", pass, i), prog[i], i);
        step();
      end
      expect_idle($sformatf("t2_p%0d_end", pass), 1);
      step();
    end

    // Looping two-word program, halted at pc=1
    do_clear();
    load_word(16'h5123);
    load_word(16'h6456);
    loop_en = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    expect_issue("t3_a0", 16'h5123, 0);
    step();
    expect_issue("t3_a1", 16'h6456, 1);
    step();
    expect_issue("t3_b0", 16'h5123, 0);
    step();
    expect_issue("t3_b1", 16'h6456, 1);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    loop_en  = 1'b0;
    expect_idle("t3_halt", 0);
    check("t3_halt_pc", 32'(pc), 1);
    step();
    check("t3_halt_nodone", 32'(done), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_issue("t3_re0", 16'h5123, 0);
    step();
    expect_issue("t3_re1", 16'h6456, 1);
    step();
    expect_idle("t3_re_end", 1);

    // Empty start, clear beats load
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    expect_idle("t4_empty_start", 0);
    step();
    check("t4_empty_nodone", 32'(done), 0);
    clear      = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h1234;
    step();
    clear      = 1'b0;
    load_valid = 1'b0;
    check("t4_clr_load_count", 32'(count), 0);

    // Same-cycle load and start on an empty store
    load_valid = 1'b1;
    load_data  = 16'h1F01;
    start      = 1'b1;
    step();
    load_valid = 1'b0;
    start      = 1'b0;
    expect_issue("t5_w0", 16'h1F01, 0);
    check("t5_count", 32'(count), 1);
    step();
    expect_idle("t5_end", 1);
    step();

    // Asynchronous reset mid-run
    do_clear();
    load_word(16'h7011);
    load_word(16'h7022);
    load_word(16'h7033);
    load_word(16'h7044);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    expect_issue("t6_pc2", 16'h7033, 2);
    rst = 1'b1;
    #1;
    expect_idle("t6_rst", 0);
    check("t6_rst_count", 32'(count), 0);
    #1;
    rst   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    expect_idle("t6_post_start", 0);
    check("t6_post_count", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Upstream feeder for the 8-bit CPU core: holds a small program and replays it to the core one instruction per clock.
- Program words are loaded through a valid/ready port, then issued on a start command.
- Each 16-bit word is {opcode[15:12], r1[11:8], r2/data[7:4], r3/data[3:0]}, the same layout the core reads from {ui_in, uio_in}.
- When not running, the block drives a harmless idle instruction so the core never sees a register-writing opcode by accident.

Parameters:
- DEPTH, 16, number of program words stored; power of two, at least 2.
- INST_W, 16, instruction word width.
- IDLE_WORD, 16'h3000, word driven while idle (RDS: no register write).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load_valid  in  1  program word offered
- load_ready  out  1  block can accept a program word
- load_data  in  INST_W  program word
- clear  in  1  discard the loaded program (IDLE only)
- start  in  1  begin issuing from address 0 (IDLE only)
- loop_en  in  1  wrap to address 0 after the last word instead of stopping
- halt_req  in  1  stop issuing (RUN only)
- inst_out  out  INST_W  instruction to the core
- inst_valid  out  1  inst_out holds a program word
- pc  out  clog2(DEPTH)  address of the word on inst_out
- count  out  clog2(DEPTH)+1  number of words loaded
- busy  out  1  state == RUN
- done  out  1  one-cycle pulse on normal end of program

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - state=IDLE, count=0, wr_ptr=0, pc=0.
  - inst_out=IDLE_WORD, inst_valid=0, busy=0, done=0.
  - Memory contents are not reset; count=0 makes them unreachable.
- States: IDLE and RUN.
- IDLE:
  - load_ready = (count < DEPTH), combinational.
  - A handshake occurs when load_valid && load_ready: mem[wr_ptr]<=load_data, wr_ptr++, count++.
  - When count==DEPTH, load_ready=0 and further load_valid is ignored; nothing is written.
  - clear: count<=0, wr_ptr<=0. If clear and a load handshake occur in the same cycle, clear wins and the word is dropped.
  - start with effective count>0: state<=RUN, inst_out<=mem[0], inst_valid<=1, pc<=0.
    - Effective count includes a word handshaken in the same cycle.
    - start with clear in the same cycle wins neither: the clear happens and the block stays in IDLE.
  - start with count==0: ignored, stays IDLE, no done pulse.
- RUN:
  - load_ready=0; clear and start are ignored.
  - Each edge with pc<count-1: pc<=pc+1, inst_out<=mem[pc+1].
  - At pc==count-1:
    - If loop_en=1: pc<=0, inst_out<=mem[0].
    - Otherwise: state<=IDLE, inst_valid<=0, inst_out<=IDLE_WORD, done<=1 for one cycle.
  - halt_req has priority over advancing: state<=IDLE, inst_valid<=0, inst_out<=IDLE_WORD, pc holds, no done pulse.
- Latency:
  - First word appears at the edge that samples start.
  - Exactly count consecutive valid cycles per pass, no gaps.
  - count=1 with loop_en=0: one valid cycle, then done.
- Invariant: inst_valid=0 implies inst_out==IDLE_WORD.
- Program retention: after done or halt, the program is kept; a new start replays from address 0.
- Reset during RUN: immediate return to reset values and the program is lost (count=0). inst_out goes to IDLE_WORD asynchronously.

Decomposition:
- Shared package holds:
  - the 4-bit opcode constants (MVR, LDB, STB, RDS, ALU ops);
  - the INST_W word-field positions;
  - IDLE_WORD;
  - the state enum {IDLE, RUN}.
- One sub-module, inst_mem: DEPTH x INST_W register array, one synchronous write port, one asynchronous read port, no reset.
- The FSM, pointers and handshake live in inst_sequencer.

Test Plan:
- Reset, then load 3 words (16'h1A55, 16'h0A0B, 16'h2B00) and pulse start -> inst_out is 1A55, 0A0B, 2B00 on 3 consecutive cycles with pc 0,1,2; done=1 on the next cycle; inst_out=16'h3000, inst_valid=0 after.
- Load 16 words -> load_ready=0 and count=16; a 17th load_valid is not written; start issues all 16 words, and a second start replays identical data.
- loop_en=1 with 2 words loaded -> issue sequence w0,w1,w0,w1...; assert halt_req while pc=1 -> next cycle inst_valid=0 and pc=1, no done pulse.
- start with count=0 -> stays IDLE, inst_valid=0, done never pulses. Same-cycle clear+load_valid -> count stays 0.
- Same-cycle load_valid(16'h1F01)+start with count=0 -> RUN issues 16'h1F01 for one cycle, then done.
- Assert rst mid-RUN at pc=2 -> inst_out=16'h3000, inst_valid=0, count=0 immediately; start after release is ignored.
